// File: rtl/hms_digit_entry.sv
// Digit-by-digit HH:MM:SS editor: captures live time, splits it into BCD digits, edits, repacks and loads.
// Optional build macro HMS_ENTRY_TIMEOUT_EN adds an EDIT inactivity timeout of TIMEOUT cycles.
module hms_digit_entry #(
   parameter int TIMEOUT = 500_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       next,
   input  logic       inc,
   input  logic       dec,
   input  logic       cancel,
   input  logic [5:0] cur_hours,
   input  logic [5:0] cur_mins,
   input  logic [5:0] cur_secs,
   output logic [5:0] hours,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic       load,
   output logic       editing,
   output logic       busy,
   output logic [2:0] cursor
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      CONV    = 3'd2,
      EDIT    = 3'd3,
      PACK    = 3'd4,
      COMMIT  = 3'd5
   } state_t;

   state_t state, state_next;

   logic [5:0] work_h, work_m, work_s;
   logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
   logic [3:0] hr_t_n, hr_u_n, mn_t_n, mn_u_n, sc_t_n, sc_u_n;
   logic       conv_done;
   logic       timeout_hit;
   logic       abort;

   // Wraps in both directions; values above max (only reachable from bad input) wrap up to 0
   function automatic logic [3:0] step_digit(input logic [3:0] v, input logic [3:0] max,
                                             input logic up);
      if (up) step_digit = (v >= max) ? 4'd0 : v + 4'd1;
      else    step_digit = (v == 4'd0) ? max : v - 4'd1;
   endfunction

   function automatic logic [5:0] pack_digits(input logic [3:0] t, input logic [3:0] u);
      logic [5:0] t6;
      t6 = {2'b00, t};
      pack_digits = (t6 << 3) + (t6 << 1) + {2'b00, u};
   endfunction

`ifdef HMS_ENTRY_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] idle_cnt;
   logic          activity;

   assign activity    = start | next | inc | dec | cancel;
   assign timeout_hit = (state == EDIT) && !activity && (idle_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           idle_cnt <= '0;
      else if (state != EDIT || activity)     idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timeout_hit    = 1'b0;
`endif

   assign abort     = cancel | timeout_hit;
   assign conv_done = (work_h < 6'd10) && (work_m < 6'd10) && (work_s < 6'd10);

   assign editing = (state == EDIT);
   assign busy    = (state == CAPTURE) || (state == CONV) || (state == PACK);
   assign load    = (state == COMMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:    state_next = start ? CAPTURE : IDLE;
         CAPTURE: state_next = abort ? IDLE : CONV;
         CONV:    state_next = abort ? IDLE : (conv_done ? EDIT : CONV);
         EDIT: begin
            if (abort)                          state_next = IDLE;
            else if (next && cursor == 3'd0)    state_next = PACK;
            else                                state_next = EDIT;
         end
         PACK:    state_next = abort ? IDLE : COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Edited digit values; the hours-units clamp follows any change that lands tens on 2
   always_comb begin
      hr_t_n = hr_t;
      hr_u_n = hr_u;
      mn_t_n = mn_t;
      mn_u_n = mn_u;
      sc_t_n = sc_t;
      sc_u_n = sc_u;
      if (state == EDIT && !abort && (inc ^ dec)) begin
         case (cursor)
            3'd5: hr_t_n = step_digit(hr_t, 4'd2, inc);
            3'd4: hr_u_n = step_digit(hr_u, (hr_t == 4'd2) ? 4'd3 : 4'd9, inc);
            3'd3: mn_t_n = step_digit(mn_t, 4'd5, inc);
            3'd2: mn_u_n = step_digit(mn_u, 4'd9, inc);
            3'd1: sc_t_n = step_digit(sc_t, 4'd5, inc);
            3'd0: sc_u_n = step_digit(sc_u, 4'd9, inc);
            default: ;
         endcase
      end
      if (hr_t_n == 4'd2 && hr_u_n > 4'd3) hr_u_n = 4'd3;
   end

   // Datapath: capture, repeated-subtraction split into digits, editing and repacking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         work_h <= '0;
         work_m <= '0;
         work_s <= '0;
         hr_t   <= '0;
         hr_u   <= '0;
         mn_t   <= '0;
         mn_u   <= '0;
         sc_t   <= '0;
         sc_u   <= '0;
         cursor <= '0;
         hours  <= '0;
         mins   <= '0;
         secs   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work_h <= cur_hours;
                  work_m <= cur_mins;
                  work_s <= cur_secs;
                  hr_t   <= '0;
                  mn_t   <= '0;
                  sc_t   <= '0;
               end
            end
            CONV: begin
               if (!abort) begin
                  if (conv_done) begin
                     hr_u   <= work_h[3:0];
                     mn_u   <= work_m[3:0];
                     sc_u   <= work_s[3:0];
                     cursor <= 3'd5;
                  end else begin
                     if (work_h >= 6'd10) begin
                        work_h <= work_h - 6'd10;
                        hr_t   <= hr_t + 4'd1;
                     end
                     if (work_m >= 6'd10) begin
                        work_m <= work_m - 6'd10;
                        mn_t   <= mn_t + 4'd1;
                     end
                     if (work_s >= 6'd10) begin
                        work_s <= work_s - 6'd10;
                        sc_t   <= sc_t + 4'd1;
                     end
                  end
               end
            end
            EDIT: begin
               hr_t <= hr_t_n;
               hr_u <= hr_u_n;
               mn_t <= mn_t_n;
               mn_u <= mn_u_n;
               sc_t <= sc_t_n;
               sc_u <= sc_u_n;
               if (!abort && next && cursor != 3'd0) cursor <= cursor - 3'd1;
            end
            PACK: begin
               if (!abort) begin
                  hours <= pack_digits(hr_t, hr_u);
                  mins  <= pack_digits(mn_t, mn_u);
                  secs  <= pack_digits(sc_t, sc_u);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
